fbuff_port_arbiter: RTL
=======================

Name: fbuff_port_arbiter

Overview:
Shares the single-port frame buffer BRAM between two requesters. The read requester is the line buffers, which fetch display rows. The write requester is a frame update source such as a pattern generator or host loader.
- Reads have priority because they are display-deadline critical.
- A starvation guard guarantees write progress.
- The block registers all memory commands and returns read data with a fixed, tagged latency.
- It sits between line_buffers/update source and frame_buffer, replacing the init/DUT mux.

Parameters:
FBUFF_ADDR_WIDTH, 15, frame buffer address width
FBUFF_DATA_WIDTH, 60, frame buffer row width (TILE_PER_ROW * PXL_WIDTH)
RD_LATENCY, 1, BRAM read latency in cycles (address registered to douta valid), range 1..3
STARVE_LIMIT, 8, consecutive cycles a pending write may be refused before it is forced, range 1..255

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  asynchronous active-high reset
rd_req_i  in  1  read request, held until rd_gnt_o
rd_addr_i  in  FBUFF_ADDR_WIDTH  read row address, stable while rd_req_i high
rd_gnt_o  out  1  read accepted this cycle
rd_data_o  out  FBUFF_DATA_WIDTH  read data
rd_valid_o  out  1  rd_data_o valid (one-cycle pulse per granted read)
wr_req_i  in  1  write request, held until wr_gnt_o
wr_addr_i  in  FBUFF_ADDR_WIDTH  write row address
wr_data_i  in  FBUFF_DATA_WIDTH  write data
wr_gnt_o  out  1  write accepted this cycle
mem_addr_o  out  FBUFF_ADDR_WIDTH  to frame_buffer addra
mem_en_o  out  1  to frame_buffer ena
mem_wen_o  out  1  to frame_buffer wea
mem_data_o  out  FBUFF_DATA_WIDTH  to frame_buffer dina
mem_data_i  in  FBUFF_DATA_WIDTH  from frame_buffer douta
wr_forced_o  out  1  pulse: the current write grant was forced by starvation

Behaviour:
Reset (rst_i high, asynchronous):
- All outputs are 0, the starvation counter is 0, and the read-valid pipeline is cleared.
- In-flight reads are discarded; no rd_valid_o is produced for them after reset.

Grant logic (combinational from the current cycle's requests and the registered counter):
- At most one grant per cycle; rd_gnt_o and wr_gnt_o are never high together.
- If wr_req_i is high and starve_cnt == STARVE_LIMIT, grant the write and pulse wr_forced_o, even if rd_req_i is high.
- Otherwise, if rd_req_i is high, grant the read.
- Otherwise, if wr_req_i is high, grant the write.
- Back-to-back grants every cycle are allowed; there are no bubbles.

Starvation counter (8-bit, saturates at STARVE_LIMIT):
- Increments on each cycle where wr_req_i is high and wr_gnt_o is low.
- Clears on wr_gnt_o or when wr_req_i is low.

Memory command (registered, cycle t+1 after a grant in cycle t):
- Read: mem_en_o=1, mem_wen_o=0, mem_addr_o=rd_addr_i.
- Write: mem_en_o=1, mem_wen_o=1, mem_addr_o=wr_addr_i, mem_data_o=wr_data_i.
- No grant: mem_en_o=0, mem_wen_o=0; mem_addr_o and mem_data_o hold their previous values.

Read return:
- A shift-register tag of depth 1+RD_LATENCY tracks each read.
- rd_valid_o pulses exactly 1+RD_LATENCY cycles after rd_gnt_o.
- rd_data_o equals mem_data_i in that same cycle (combinational pass-through, qualified by the tag).
- Write grants insert no tag. Read data order always equals grant order.

Requester protocol violations:
- A request dropped before its grant is simply not served.
- No state is retained for it.

Read-after-write to the same address:
- A write granted at t followed by a read granted at t+1 returns the new data, because the BRAM commands are issued in order.

Test Plan:
- Reset, then rd_req_i=1 with rd_addr_i=0x0010 for one grant, RD_LATENCY=1 -> rd_gnt_o at t0; mem_en_o=1, wen=0, addr=0x0010 at t0+1; rd_valid_o=1 at t0+2 carrying the preloaded row; no other valid pulses.
- rd_req_i held high continuously and wr_req_i high from cycle 0, STARVE_LIMIT=8 -> reads are granted on cycles 0..7; on cycle 8 wr_gnt_o=1 and wr_forced_o=1 while rd_gnt_o=0; reads resume at cycle 9; the counter restarts at 0.
- Write addr 0x0005 data 0xABC at cycle t, read 0x0005 at t+1 -> rd_valid_o at t+3 (RD_LATENCY=1) with data 0xABC.
- Interleaved pattern R,W,R,R with RD_LATENCY=2 -> exactly three rd_valid_o pulses, each 3 cycles after its grant, in grant order, with data matching the addresses.
- Assert rst_i for 1 cycle while 2 reads are in flight -> no rd_valid_o afterwards; all outputs 0 during reset; the first grant after release behaves as in scenario 1.
- Idle (no requests) for 20 cycles -> mem_en_o=0 throughout, the counter stays 0, and no grants occur.

Source files
------------

// File: rtl/fbuff_port_arbiter.sv
// Frame buffer port arbiter: shares the single-port frame buffer BRAM between
// the display read path (priority) and a frame update write path. A starvation
// counter forces a write through after STARVE_LIMIT consecutive refusals.
// Memory commands are registered; read data returns with a fixed latency and
// is qualified by a tag shift register so only granted reads produce a pulse.
module fbuff_port_arbiter #(
    parameter int FBUFF_ADDR_WIDTH = 15,
    parameter int FBUFF_DATA_WIDTH = 60,
    parameter int RD_LATENCY       = 1,
    parameter int STARVE_LIMIT     = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rd_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] rd_addr_i,
    output logic                        rd_gnt_o,
    output logic [FBUFF_DATA_WIDTH-1:0] rd_data_o,
    output logic                        rd_valid_o,
    input  logic                        wr_req_i,
    input  logic [FBUFF_ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [FBUFF_DATA_WIDTH-1:0] wr_data_i,
    output logic                        wr_gnt_o,
    output logic [FBUFF_ADDR_WIDTH-1:0] mem_addr_o,
    output logic                        mem_en_o,
    output logic                        mem_wen_o,
    output logic [FBUFF_DATA_WIDTH-1:0] mem_data_o,
    input  logic [FBUFF_DATA_WIDTH-1:0] mem_data_i,
    output logic                        wr_forced_o
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0]          starve_cnt;
    logic                force_wr;
    logic                rd_gnt;
    logic                wr_gnt;
    // Bit 0 marks a read command on the BRAM port; bit RD_LATENCY marks douta valid.
    logic [RD_LATENCY:0] rd_tag;

    // Grant decision: forced write beats read, read beats unforced write.
    // Grants are suppressed while reset is held so every output reads 0.
    always_comb begin
        force_wr = 1'b0;
        rd_gnt   = 1'b0;
        wr_gnt   = 1'b0;
        if (!rst_i) begin
            force_wr = wr_req_i && (starve_cnt == LIMIT);
            wr_gnt   = wr_req_i && (force_wr || !rd_req_i);
            rd_gnt   = rd_req_i && !force_wr;
        end
    end

    assign rd_gnt_o    = rd_gnt;
    assign wr_gnt_o    = wr_gnt;
    assign wr_forced_o = force_wr;

    // Starvation counter: counts consecutive refused cycles of a pending write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= 8'd0;
        end else if (wr_req_i && !wr_gnt) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end else begin
            starve_cnt <= 8'd0;
        end
    end

    // Registered BRAM command; address and data hold when the port is idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_en_o   <= 1'b0;
            mem_wen_o  <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            mem_en_o  <= rd_gnt || wr_gnt;
            mem_wen_o <= wr_gnt;
            if (wr_gnt) begin
                mem_addr_o <= wr_addr_i;
                mem_data_o <= wr_data_i;
            end else if (rd_gnt) begin
                mem_addr_o <= rd_addr_i;
            end
        end
    end

    // Read tag pipeline: one bit per granted read, cleared on reset so
    // in-flight reads never produce a valid pulse after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_tag <= '0;
        end else begin
            rd_tag <= {rd_tag[RD_LATENCY-1:0], rd_gnt};
        end
    end

    assign rd_valid_o = rd_tag[RD_LATENCY];
    assign rd_data_o  = rd_valid_o ? mem_data_i : '0;

endmodule
